csa_stream_accumulator: RTL



---
 rtl/csa_stream_accumulator_pkg.sv | 21 ++
 rtl/csa_stream_accumulator_if.sv | 39 +++
 rtl/csa_stream_accumulator_adder.sv | 32 +++
 rtl/csa_stream_accumulator.sv | 95 +++++++++
 4 files changed

// File: rtl/csa_stream_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Package    : csa_pkg
// Description: Shared types and constants for the CSA stream accumulator:
//              FSM state encoding, datapath width and saturation value.
// Revision   : 1.0  initial release
// ============================================================================
package csa_pkg;

   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] SAT_VAL = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } csa_acc_state_t;

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_stream_accumulator_if.sv
`default_nettype none
// ============================================================================
// Interface  : csa_stream_accumulator_if
// Description: Job-control, operand-stream and result signals of the CSA
//              stream accumulator.
//              master : job source / operand producer / result consumer
//              slave  : the accumulator
//   start, len          job request (len operands)
//   in_valid/in_ready   operand handshake, in_data operand
//   out_valid/out_ready result handshake, out_sum / out_carry_cnt result
//   busy                job in progress or result pending
// Revision   : 1.0  initial release
// ============================================================================
interface csa_stream_accumulator_if #(
   parameter int CNT_W = 4
);
   logic                        start;
   logic [CNT_W-1:0]            len;
   logic                        in_valid;
   logic [csa_pkg::DATA_W-1:0]  in_data;
   logic                        in_ready;
   logic                        out_valid;
   logic [csa_pkg::DATA_W-1:0]  out_sum;
   logic [CNT_W-1:0]            out_carry_cnt;
   logic                        out_ready;
   logic                        busy;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_carry_cnt, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_carry_cnt, busy
   );

endinterface : csa_stream_accumulator_if
`default_nettype wire

// File: rtl/csa_stream_accumulator_adder.sv
`default_nettype none
// ============================================================================
// Module     : csa_stream_accumulator_adder
// Description: Combinational 8-bit carry-select adder. The low nibble is a
//              plain add; the high nibble is precomputed for both possible
//              carry-ins and the low-nibble carry selects between them.
//   a, b   : operands
//   sum    : a + b (mod 256)
//   carry  : carry-out of bit 7
// Revision   : 1.0  initial release
// ============================================================================
module csa_stream_accumulator_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   output logic       carry
);

   logic [4:0] w_lo;
   logic [4:0] w_hi_c0;
   logic [4:0] w_hi_c1;

   assign w_lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]};
   assign w_hi_c0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
   assign w_hi_c1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

   assign sum[3:0] = w_lo[3:0];
   assign sum[7:4] = w_lo[4] ? w_hi_c1[3:0] : w_hi_c0[3:0];
   assign carry    = w_lo[4] ? w_hi_c1[4]   : w_hi_c0[4];

endmodule : csa_stream_accumulator_adder
`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module     : csa_stream_accumulator
// Description: Accumulates a stream of len 8-bit operands through one
//              carry-select adder pass per operand (A = running sum,
//              B = operand). The result is the low 8 bits of the total plus
//              the number of adder carry-outs: total = carry_cnt*256 + sum.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csa_stream_accumulator_if.slave (job, operand, result)
// Optional   : `define CSA_ACC_SAT_EN -> the first carry-out saturates the
//              running sum to 8'hFF for the rest of the job.
// Revision   : 1.0  initial release
// ============================================================================
module csa_stream_accumulator
   import csa_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   csa_stream_accumulator_if.slave  bus
);

   csa_acc_state_t    r_state;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_carry_cnt;
   logic [CNT_W-1:0]  r_remaining;

   logic [DATA_W-1:0] w_sum;
   logic              w_carry;
   logic              w_fire;

   csa_stream_accumulator_adder u_adder (
      .a     (r_acc),
      .b     (bus.in_data),
      .sum   (w_sum),
      .carry (w_carry)
   );

   // in_ready is a pure state decode so it never depends on in_valid.
   assign bus.in_ready      = (r_state == ACCUM);
   assign w_fire            = bus.in_valid && bus.in_ready;

   assign bus.out_valid     = (r_state == DONE);
   assign bus.busy          = (r_state != IDLE);
   // Result registers double as the outputs; they hold the last job's value
   // while idle and only clear when a new job is accepted.
   assign bus.out_sum       = r_acc;
   assign bus.out_carry_cnt = r_carry_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_carry_cnt <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_acc       <= '0;
                  r_carry_cnt <= '0;
                  r_remaining <= bus.len;
                  r_state     <= (bus.len == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (w_fire) begin
`ifdef CSA_ACC_SAT_EN
                  // Once at 8'hFF every further add either carries (stays
                  // saturated) or adds zero, so no sticky flag is needed.
                  r_acc       <= w_carry ? SAT_VAL : w_sum;
`else
                  r_acc       <= w_sum;
`endif
                  // Cannot wrap: at most len <= 2^CNT_W-1 carries per job.
                  r_carry_cnt <= r_carry_cnt + CNT_W'(w_carry);
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == CNT_W'(1)) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule : csa_stream_accumulator
`default_nettype wire
